// File: rtl/ov9281_pkg.sv
// rtl/ov9281_pkg.sv - shared register map, chip ID, write record and bus state encoding
package ov9281_pkg;

  localparam logic [15:0] ADDR_MODE_SELECT  = 16'h0100;
  localparam logic [15:0] ADDR_SOFT_RESET   = 16'h0103;
  localparam logic [15:0] ADDR_CHIP_ID_H    = 16'h300A;
  localparam logic [15:0] ADDR_CHIP_ID_L    = 16'h300B;
  localparam logic [15:0] ADDR_REG_3662     = 16'h3662;
  localparam logic [15:0] ADDR_REG_4800     = 16'h4800;
  localparam logic [15:0] ADDR_ISP_CTRL     = 16'h5E00;
  localparam logic [15:0] ADDR_SCRATCH_BASE = 16'h3800;
  localparam int          SCRATCH_DEPTH     = 32;
  localparam logic [15:0] CHIP_ID           = 16'h9281;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } reg_write_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_AHI,
    ST_AHI_ACK,
    ST_ALO,
    ST_ALO_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK,
    ST_IGNORE
  } i2c_state_t;

  // The scratch window is 32 bytes aligned on 0x3800, so the upper 11 bits identify it.
  function automatic logic in_scratch(input logic [15:0] a);
    return a[15:5] == ADDR_SCRATCH_BASE[15:5];
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with SCL edge and START/STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl;
  logic                   scl_q;
  logic                   sda_q;

  assign scl = scl_pipe[SYNC_STAGES-1];
  assign sda = sda_pipe[SYNC_STAGES-1];

  // Shift pad values through the synchronizer and keep one extra sample for edge detection;
  // everything resets to 1 so an idle bus does not look like an edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_pipe[0] <= scl_in;
      sda_pipe[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_pipe[i] <= scl_pipe[i-1];
        sda_pipe[i] <= sda_pipe[i-1];
      end
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  // SDA may only change while SCL is high for a bus condition, so both SCL samples must be high.
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/ov9281_i2c_target.sv
// rtl/ov9281_i2c_target.sv - OV9281-style I2C register target with 16-bit register pointer
module ov9281_i2c_target
  import ov9281_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h60,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  output logic        o_busy,
  output logic        o_wr_strobe,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_streaming,
  output logic        o_test_pattern
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .scl_in  (i_scl),
    .sda_in  (i_sda),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  i2c_state_t  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [7:0]  sh, sh_nx;
  logic [7:0]  tx, tx_nx;
  logic [15:0] ptr, ptr_nx;
  logic [7:0]  ahi, ahi_nx;
  logic        rw, rw_nx;
  reg_write_t  wr_q, wr_nx;
  logic        strobe_q, strobe_nx;

  logic [7:0]  reg_0100, reg_3662, reg_4800, reg_5e00;
  logic [7:0]  scratch [SCRATCH_DEPTH];
  logic [15:0] rd_addr;
  logic [7:0]  rd_byte;

  // Bus state and datapath registers; reset releases SDA at once because o_sda_oe decodes state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sh       <= '0;
      tx       <= '0;
      ptr      <= '0;
      ahi      <= '0;
      rw       <= 1'b0;
      wr_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sh       <= sh_nx;
      tx       <= tx_nx;
      ptr      <= ptr_nx;
      ahi      <= ahi_nx;
      rw       <= rw_nx;
      wr_q     <= wr_nx;
      strobe_q <= strobe_nx;
    end
  end

  // Next-state logic: bits are sampled on SCL rise, every state change happens on SCL fall,
  // and START/STOP override both so a partial byte is simply dropped.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sh_nx     = sh;
    tx_nx     = tx;
    ptr_nx    = ptr;
    ahi_nx    = ahi;
    rw_nx     = rw;
    wr_nx     = wr_q;
    strobe_nx = 1'b0;
    if (start) begin
      state_nx = ST_DEV;
      cnt_nx   = '0;
    end else if (stop) begin
      state_nx = ST_IDLE;
    end else begin
      if (scl_rise && state != ST_IDLE && state != ST_IGNORE) begin
        sh_nx  = {sh[6:0], sda};
        cnt_nx = cnt + 4'd1;
      end
      if (scl_fall) begin
        case (state)
          ST_DEV: if (cnt == 4'd8) begin
            if (sh[7:1] == DEV_ADDR) begin
              state_nx = ST_DEV_ACK;
              rw_nx    = sh[0];
            end else begin
              state_nx = ST_IGNORE;
            end
          end
          ST_DEV_ACK: begin
            cnt_nx = '0;
            if (rw) begin
              state_nx = ST_RDATA;
              tx_nx    = rd_byte;
            end else begin
              state_nx = ST_AHI;
            end
          end
          ST_AHI: if (cnt == 4'd8) begin
            state_nx = ST_AHI_ACK;
            ahi_nx   = sh;
          end
          ST_AHI_ACK: begin
            state_nx = ST_ALO;
            cnt_nx   = '0;
          end
          ST_ALO: if (cnt == 4'd8) begin
            state_nx = ST_ALO_ACK;
            ptr_nx   = {ahi, sh};
          end
          ST_ALO_ACK: begin
            state_nx = ST_WDATA;
            cnt_nx   = '0;
          end
          ST_WDATA: if (cnt == 4'd8) begin
            state_nx   = ST_WDATA_ACK;
            wr_nx.addr = ptr;
            wr_nx.data = sh;
            strobe_nx  = 1'b1;
            ptr_nx     = ptr + 16'd1;
          end
          ST_WDATA_ACK: begin
            state_nx = ST_WDATA;
            cnt_nx   = '0;
          end
          ST_RDATA: begin
            if (cnt == 4'd8) state_nx = ST_RD_MACK;
            else             tx_nx    = {tx[6:0], 1'b0};
          end
          ST_RD_MACK: begin
            if (!sh[0]) begin
              state_nx = ST_RDATA;
              cnt_nx   = '0;
              ptr_nx   = ptr + 16'd1;
              tx_nx    = rd_byte;
            end else begin
              state_nx = ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux: during the master ACK slot the next byte is fetched from the incremented pointer.
  always_comb begin
    rd_addr = (state == ST_RD_MACK) ? ptr + 16'd1 : ptr;
    rd_byte = 8'h00;
    if (in_scratch(rd_addr)) begin
      rd_byte = scratch[rd_addr[4:0]];
    end else begin
      case (rd_addr)
        ADDR_MODE_SELECT: rd_byte = reg_0100;
        ADDR_CHIP_ID_H:   rd_byte = CHIP_ID[15:8];
        ADDR_CHIP_ID_L:   rd_byte = CHIP_ID[7:0];
        ADDR_REG_3662:    rd_byte = reg_3662;
        ADDR_REG_4800:    rd_byte = reg_4800;
        ADDR_ISP_CTRL:    rd_byte = reg_5e00;
        default:          rd_byte = 8'h00;
      endcase
    end
  end

  // Register file update one cycle after the write strobe; soft reset clears every RW byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reg_0100 <= '0;
      reg_3662 <= '0;
      reg_4800 <= '0;
      reg_5e00 <= '0;
      for (int i = 0; i < SCRATCH_DEPTH; i++) scratch[i] <= '0;
    end else if (strobe_q) begin
      if (wr_q.addr == ADDR_SOFT_RESET) begin
        if (wr_q.data[0]) begin
          reg_0100 <= '0;
          reg_3662 <= '0;
          reg_4800 <= '0;
          reg_5e00 <= '0;
          for (int i = 0; i < SCRATCH_DEPTH; i++) scratch[i] <= '0;
        end
      end else if (in_scratch(wr_q.addr)) begin
        scratch[wr_q.addr[4:0]] <= wr_q.data;
      end else begin
        case (wr_q.addr)
          ADDR_MODE_SELECT: reg_0100 <= wr_q.data;
          ADDR_REG_3662:    reg_3662 <= wr_q.data;
          ADDR_REG_4800:    reg_4800 <= wr_q.data;
          ADDR_ISP_CTRL:    reg_5e00 <= wr_q.data;
          default: ;
        endcase
      end
    end
  end

  // SDA drive: low for every target ACK slot, inverted data bit while shifting a read byte.
  always_comb begin
    case (state)
      ST_DEV_ACK, ST_AHI_ACK, ST_ALO_ACK, ST_WDATA_ACK: o_sda_oe = 1'b1;
      ST_RDATA:                                         o_sda_oe = ~tx[7];
      default:                                          o_sda_oe = 1'b0;
    endcase
  end

  assign o_busy         = (state != ST_IDLE);
  assign o_wr_strobe    = strobe_q;
  assign o_wr_addr      = wr_q.addr;
  assign o_wr_data      = wr_q.data;
  assign o_streaming    = reg_0100[0];
  assign o_test_pattern = reg_5e00[7];

endmodule

// File: doc/ov9281_i2c_target.md
OV9281_I2C_TARGET -- requirements
Module: ov9281_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h60, 7-bit target address (write byte 0xC0, read byte 0xC1).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on SCL/SDA inputs.
REQ-003 i_clk  input  1  system clock, one clock domain.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_scl  input  1  I2C SCL from pad; the target never drives SCL (no clock stretching).
REQ-006 i_sda  input  1  I2C SDA from pad.
REQ-007 o_sda_oe  output  1  1 = pull SDA low; 0 = release.
REQ-008 o_busy  output  1  high from START to STOP inclusive.
REQ-009 o_wr_strobe  output  1  one-cycle pulse per accepted data byte.
REQ-010 o_wr_addr  output  16  register address of the pulsed write.
REQ-011 o_wr_data  output  8  data of the pulsed write.
REQ-012 o_streaming  output  1  bit0 of register 0x0100.
REQ-013 o_test_pattern  output  1  bit7 of register 0x5E00.

Function
REQ-014 SCL/SDA pass through SYNC_STAGES flops; edges are detected on synchronized values; SDA is sampled on the SCL rising edge.
REQ-015 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are recognized in every state and take priority over bit processing.
REQ-016 States: IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
REQ-017 START -> DEV, bit counter = 0; STOP -> IDLE.
REQ-018 DEV collects 8 bits MSB first. If addr = DEV_ADDR, go to DEV_ACK; otherwise go to IGNORE (no ACK, o_sda_oe held 0 until START/STOP).
REQ-019 ACK drive: o_sda_oe asserts on the SCL falling edge after bit 8 and releases on the next SCL falling edge.
REQ-020 Write path: DEV_ACK(R/W=0) -> AHI -> AHI_ACK -> ALO -> ALO_ACK -> WDATA -> WDATA_ACK -> WDATA. This sets pointer = {AHI, ALO}.
REQ-021 Each WDATA byte is ACKed and written at the pointer, o_wr_strobe pulses, and the pointer then increments mod 2^16 (0xFFFF wraps to 0x0000).
REQ-022 Read path: DEV_ACK(R/W=1) -> RDATA. The byte at the pointer is loaded at the DEV_ACK release edge and shifted out MSB first; o_sda_oe = ~bit, changed only on SCL falling edges.
REQ-023 After 8 read bits the target releases SDA and samples the master ACK. ACK (0) -> pointer+1, RDATA; NACK (1) -> IGNORE.
REQ-024 Repeated START keeps the pointer, so write-address-then-read works.
REQ-025 Register map:
- 0x0100 RW.
- 0x0103 W: bit0=1 resets all RW registers to 0x00 one cycle after WDATA_ACK; reads return 0x00.
- 0x300A RO 0x92; 0x300B RO 0x81.
- 0x3662, 0x4800, 0x5E00 RW.
- 0x3800-0x381F: 32-byte RW scratch array.
- Unmapped: write ACKed and discarded (strobe still pulses); read returns 0x00.
REQ-026 Writes to RO addresses are ACKed and ignored.
REQ-027 Every data byte is ACKed (no NACK on data).
REQ-028 STOP or START mid-byte aborts the partial byte with no register update; a START in that case re-enters DEV.

Reset
REQ-029 Reset values:
- State IDLE; pointer 0x0000.
- All RW registers and scratch bytes 0x00.
- o_sda_oe, o_busy, o_wr_strobe = 0; o_wr_addr = 0x0000; o_wr_data = 0x00.
- o_streaming, o_test_pattern = 0.
- Synchronizer flops = 1 (idle bus).
REQ-030 Reset mid-transaction releases SDA immediately (asynchronously).

Structure
REQ-031 Shared package ov9281_pkg holds the register address constants, chip ID 16'h9281, the reg_write_t struct and the state enum; the initiator sequencer imports the same package.
REQ-032 One sub-module, i2c_bus_sync: synchronizer plus SCL rise/fall and START/STOP detect.
REQ-033 Target size is 200-350 lines of RTL.

Verification
REQ-034 Write {0xC0, 0x01, 0x00, 0x01} then STOP -> 4 ACKs, o_wr_strobe with addr 0x0100 data 0x01, o_streaming = 1.
REQ-035 {0xC0, 0x30, 0x0A}, repeated START, {0xC1}, read 2 bytes with ACK then NACK -> bytes 0x92, 0x81; SDA released after the NACK.
REQ-036 Wrong address 0xA0 -> no ACK, o_sda_oe stays 0 through STOP, no strobe.
REQ-037 Burst write 0x381E: {0xAA, 0xBB, 0xCC}, then read back from 0x381E -> 0xAA, 0xBB, 0x00 (0x3820 is unmapped).
REQ-038 Set 0x5E00 = 0x80, then write 0x0103 = 0x01 -> o_test_pattern falls one cycle after the ACK; 0x300A still reads 0x92.
REQ-039 Assert i_rst_n low during RDATA -> o_sda_oe = 0 asynchronously; after release, the next transaction decodes normally.
